// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and default bit timing.
// The transmit side imports this package too.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// The reset value is a parameter so idle-high lines do not look like an edge when reset is released.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-sampling FSM, valid/ack byte handshake, framing-error and overrun pulses.
// A held-low line after a bad stop bit is parked in BREAK rather than decoded as repeated 0x00 frames.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 frame_error,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

    logic rx_s;

    uart_rx_state_t       state,       state_next;
    logic [CNT_W-1:0]     clk_cnt,     clk_cnt_next;
    logic [BIT_W-1:0]     bit_cnt,     bit_cnt_next;
    logic [DATA_BITS-1:0] shreg,       shreg_next;
    logic [DATA_BITS-1:0] rx_data_next;
    logic                 rx_valid_next;
    logic                 frame_error_next;
    logic                 overrun_next;

    sync_2ff #(
        .RESET_VALUE(1'b1)
    ) u_sync_rx (
        .clk    (clk),
        .reset_n(reset_n),
        .d      (serial_in),
        .q      (rx_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_next;
            clk_cnt     <= clk_cnt_next;
            bit_cnt     <= bit_cnt_next;
            shreg       <= shreg_next;
            rx_data     <= rx_data_next;
            rx_valid    <= rx_valid_next;
            frame_error <= frame_error_next;
            overrun     <= overrun_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first, so no path can leave one unassigned and infer a latch.
        state_next       = state;
        clk_cnt_next     = clk_cnt;
        bit_cnt_next     = bit_cnt;
        shreg_next       = shreg;
        rx_data_next     = rx_data;
        rx_valid_next    = rx_valid;
        frame_error_next = 1'b0;
        overrun_next     = 1'b0;

        if (rx_ack && rx_valid) begin
            rx_valid_next = 1'b0;
        end

        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next   = START;
                    clk_cnt_next = '0;
                end
            end

            START: begin
                if (clk_cnt == HALF_LAST) begin
                    clk_cnt_next = '0;
                    bit_cnt_next = '0;
                    state_next   = rx_s ? IDLE : DATA;
                end else begin
                    clk_cnt_next = clk_cnt + CNT_W'(1);
                end
            end

            DATA: begin
                if (clk_cnt == BIT_LAST) begin
                    clk_cnt_next = '0;
                    shreg_next   = {rx_s, shreg[DATA_BITS-1:1]};
                    if (bit_cnt == LAST_BIT) begin
                        state_next = STOP;
                    end else begin
                        bit_cnt_next = bit_cnt + BIT_W'(1);
                    end
                end else begin
                    clk_cnt_next = clk_cnt + CNT_W'(1);
                end
            end

            STOP: begin
                if (clk_cnt == BIT_LAST) begin
                    clk_cnt_next = '0;
                    if (rx_s) begin
                        state_next = IDLE;
                        // An ack landing on the stop-sample edge frees the holding register first.
                        if (!rx_valid || rx_ack) begin
                            rx_data_next  = shreg;
                            rx_valid_next = 1'b1;
                        end else begin
                            overrun_next = 1'b1;
                        end
                    end else begin
                        state_next       = BREAK;
                        frame_error_next = 1'b1;
                    end
                end else begin
                    clk_cnt_next = clk_cnt + CNT_W'(1);
                end
            end

            BREAK: begin
                if (rx_s) begin
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CLKS_PER_BIT = 8: directed scenarios plus random bytes
// compared against a frame-level model of what the consumer should see.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB = 8;

    logic       clk;
    logic       reset_n;
    logic       serial_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       frame_error;
    logic       overrun;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    int cyc      = 0;
    int fe_seen  = 0;
    int ov_seen  = 0;
    int rise_cyc = -1;
    logic valid_d = 1'b0;

    // Frame-level model of the consumer-visible state.
    logic [7:0] exp_data  = 8'h00;
    logic       exp_valid = 1'b0;
    int         exp_fe    = 0;
    int         exp_ov    = 0;

    uart_rx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .serial_in  (serial_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ack     (rx_ack),
        .frame_error(frame_error),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_error) fe_seen <= fe_seen + 1;
        if (overrun)     ov_seen <= ov_seen + 1;
        if (rx_valid && !valid_d) rise_cyc <= cyc;
        valid_d <= rx_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_stop(input logic [7:0] b, input logic stop, input logic ack);
        if (stop) begin
            if (!exp_valid || ack) begin
                exp_data  = b;
                exp_valid = 1'b1;
            end else begin
                exp_ov++;
            end
        end else begin
            exp_fe++;
            if (ack) exp_valid = 1'b0;
        end
    endfunction

    // Sends one 8N1 frame starting at a negedge; optionally acks on the stop-sample edge.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic ack_at_stop);
        serial_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            serial_in = b[k];
            repeat (CPB) @(negedge clk);
        end
        serial_in = stop;
        repeat (CPB - 2) @(negedge clk);
        rx_ack = ack_at_stop;
        @(negedge clk);
        rx_ack = 1'b0;
        @(negedge clk);
        model_stop(b, stop, ack_at_stop);
    endtask

    task automatic do_ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        exp_valid = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_valid"}, 32'(rx_valid), 32'(exp_valid));
        check({tag, "_data"},  32'(rx_data),  32'(exp_data));
        check({tag, "_ov"},    32'(ov_seen),  32'(exp_ov));
        check({tag, "_fe"},    32'(fe_seen),  32'(exp_fe));
    endtask

    initial begin
        int f;
        logic [7:0] b;

        reset_n   = 1'b0;
        serial_in = 1'b1;
        rx_ack    = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_data",  32'(rx_data),     32'h0);
        check("rst_valid", 32'(rx_valid),    32'h0);
        check("rst_fe",    32'(frame_error), 32'h0);
        check("rst_ov",    32'(overrun),     32'h0);
        check("rst_busy",  32'(busy),        32'h0);
        check("rst_state", 32'(dut.state),   32'(IDLE));

        // Ack while nothing is pending is ignored
        do_ack();
        @(negedge clk);
        check("stray_ack", 32'(rx_valid), 32'h0);

        // Single frame with exact latency
        f = cyc;
        send_frame(8'hA5, 1'b1, 1'b0);
        check("a5_latency", 32'(rise_cyc - f), 32'(2 + CPB / 2 + 9 * CPB + 1));
        check_model("a5");
        repeat (5) @(negedge clk);
        check("a5_hold", 32'(rx_valid), 32'h1);
        do_ack();
        check("a5_ack_clear", 32'(rx_valid), 32'h0);

        // Glitch
        repeat (4) @(negedge clk);
        serial_in = 1'b0;
        repeat (2) @(negedge clk);
        serial_in = 1'b1;
        @(negedge clk);
        check("glitch_busy_hi", 32'(busy), 32'h1);
        repeat (20) @(negedge clk);
        check("glitch_busy_lo", 32'(busy),      32'h0);
        check("glitch_state",   32'(dut.state), 32'(IDLE));
        check_model("glitch");

        // Framing error followed by a held-low line
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        check("brk_busy", 32'(busy), 32'h1);
        check_model("ferr");
        serial_in = 1'b1;
        repeat (6) @(negedge clk);
        check("brk_exit", 32'(busy), 32'h0);
        send_frame(8'h7E, 1'b1, 1'b0);
        check_model("after_brk");
        do_ack();

        // Overrun: two frames back-to-back with no ack
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        check_model("overrun");
        check("overrun_keep", 32'(rx_data), 32'h11);
        do_ack();

        // Ack coinciding with the second stop sample
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b1);
        check_model("ack_at_stop");
        check("ack_at_stop_data", 32'(rx_data), 32'h22);

        // Reset during data bit 4 with a byte still pending
        b = 8'h5A;
        serial_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            serial_in = b[k];
            repeat (CPB) @(negedge clk);
        end
        serial_in = b[4];
        repeat (CPB / 2) @(negedge clk);
        reset_n   = 1'b0;
        serial_in = 1'b1;
        repeat (2) @(negedge clk);
        check("mrst_data",  32'(rx_data),  32'h0);
        check("mrst_valid", 32'(rx_valid), 32'h0);
        check("mrst_busy",  32'(busy),     32'h0);
        reset_n   = 1'b1;
        exp_valid = 1'b0;
        exp_data  = 8'h00;
        repeat (CPB * 10) @(negedge clk);
        check_model("mrst_idle");
        send_frame(8'h00, 1'b1, 1'b0);
        check_model("zero_frame");
        do_ack();

        // Random bytes, gaps and ack timing
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            if ($urandom_range(0, 1) == 1) do_ack();
            send_frame(b, 1'b1, ($urandom_range(0, 3) == 0));
            check_model($sformatf("rand%0d", i));
        end

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

- Serial receiver for the UART link; the counterpart of the byte transmit shift register.
- Frames are 8N1: idle-high line, start bit 0, eight data bits LSB first, stop bit 1.
- The block oversamples `serial_in` with the system clock, centre-samples each bit and presents the byte on a valid/ack handshake to the core-side register interface.
- It flags framing errors and overruns.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868, system clocks per bit (100 MHz / 115200). Must be ≥ 4; even values are recommended.

Ports:
- `clk`, input, 1, system clock; all state updates on the rising edge.
- `reset_n`, input, 1, asynchronous, active-low reset.
- `serial_in`, input, 1, asynchronous UART line; idles high.
- `rx_data`, output, 8, last received byte; held stable while `rx_valid` is high.
- `rx_valid`, output, 1, byte available; level signal held until acknowledged.
- `rx_ack`, input, 1, consumer accepts the byte; only meaningful while `rx_valid` is high.
- `frame_error`, output, 1, one-cycle pulse when the stop bit samples 0.
- `overrun`, output, 1, one-cycle pulse when a good frame completes while `rx_valid` is still high.
- `busy`, output, 1, high in any state other than IDLE.

## Operation
- `serial_in` passes through a 2-FF synchronizer; the synchronizer flops reset to 1. All decisions use the synchronized bit `rx_s`.
- Bit counter: counts 0–7. Clock counter: `$clog2(CLKS_PER_BIT)` bits.

FSM states and transitions:
- **IDLE**: `rx_s == 0` → START, clock counter cleared.
- **START**: wait until clock counter reaches `CLKS_PER_BIT/2 - 1`, then sample `rx_s`.
  - Sample is 1 → glitch; return to IDLE with no outputs.
  - Sample is 0 → DATA, clock counter cleared, bit counter cleared.
- **DATA**: every `CLKS_PER_BIT` clocks (counter reaches `CLKS_PER_BIT - 1`), sample `rx_s` into the shift register with `shreg <= {rx_s, shreg[7:1]}`, so the first bit ends up in bit 0. After the 8th sample → STOP.
- **STOP**: after `CLKS_PER_BIT` clocks, sample `rx_s`.
  - Sample is 1 and `rx_valid == 0` → load `rx_data <= shreg`, set `rx_valid`; → IDLE.
  - Sample is 1 and `rx_valid == 1` → pulse `overrun`. The old `rx_data` is kept and the new byte is discarded. → IDLE.
  - Sample is 0 → pulse `frame_error`. No data is delivered and `rx_valid` is unchanged. → BREAK.
- **BREAK**: stay until `rx_s == 1`, then → IDLE. This prevents a held-low line (break) from being decoded as repeated 0x00 frames.

Handshake:
- `rx_ack` while `rx_valid` is high clears `rx_valid` on the next edge.
- `rx_ack` while `rx_valid` is low is ignored.

Simultaneous events:
- Stop sample in the same cycle as `rx_ack` with `rx_valid` high: the ack wins first. The new byte loads, `rx_valid` stays 1, and no overrun is reported.

Reset (at any time, including mid-frame):
- Return to IDLE; counters, shift register and `rx_data` are cleared to 0.
- `rx_valid`, `frame_error`, `overrun` and `busy` go to 0.
- After reset release, a line that is already low is treated as a start edge.

## Timing
- Synchronizer latency: 2 clocks from a `serial_in` change to `rx_s`.
- START is entered on the edge after `rx_s` first reads 0.
- Start sample: `CLKS_PER_BIT/2` clocks after entering START.
- Data bit k (k = 0–7) is sampled `CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT` clocks after entering START.
- Stop sample: 9 bit times plus a half bit after entering START.
- `rx_valid`, `frame_error` and `overrun` become visible the cycle after the stop-sample edge.
- Return to IDLE immediately follows the stop sample, so back-to-back frames are accepted with no idle gap.
- The receiver tolerates a rate mismatch of ±2 % at `CLKS_PER_BIT ≥ 16`.

## Structure
- **`uart_pkg`**:
  - `typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t`.
  - `localparam DATA_BITS = 8`.
  - `localparam DEFAULT_CLKS_PER_BIT = 868`.
  - The transmit side shares the same package.
- **Sub-module `sync_2ff`**:
  - Parameter: reset value.
  - Ports: `clk`, `reset_n`, `d`, `q`.
  - Reused for every asynchronous input in the design.
- **`uart_rx`** itself contains:
  - the FSM, both counters and the shift register;
  - the output registers.

## Test plan
All scenarios use `CLKS_PER_BIT = 8`, with the bench driving an ideal bit period of 8 clocks.
- **Reset state**: hold `reset_n = 0` with `serial_in = 1`, then release. All outputs read 0, `busy = 0`, and state is IDLE.
- **Single frame**: send 0xA5 (line sequence 0,1,0,1,0,0,1,0,1,1).
  - `rx_data = 0xA5` and `rx_valid = 1`, exactly 2 + 4 + 9·8 + 1 clocks after the first falling edge.
  - `rx_valid` stays high until `rx_ack`, then clears one cycle later.
- **Glitch**: pulse `serial_in` low for 2 clocks. No `rx_valid`, `busy` returns to 0, and state is IDLE.
- **Framing error**: send 0x3C with stop bit 0, then hold the line low for 40 clocks.
  - `frame_error` pulses exactly once and `rx_valid` stays 0.
  - After the line goes high, send 0x7E: it is received correctly.
- **Overrun**: send 0x11 then 0x22 back-to-back with no ack.
  - `overrun` pulses once, `rx_data` remains 0x11.
  - Ack in the same cycle as the second stop sample instead: `rx_data = 0x22`, no overrun.
- **Reset mid-frame**: assert `reset_n` low during data bit 4 of a frame.
  - Outputs clear and no byte is delivered.
  - A following 0x00 frame is received correctly.
